// File: rtl/odd_parity_tx_if.sv
// rtl/odd_parity_tx_if.sv - word handshake between the data source and odd_parity_tx
//
// Signals:
//   data_in   source -> tx   word to send, sampled only on accept
//   valid_in  source -> tx   source has a word on data_in
//   ready_out tx -> source   transmitter can accept a word this cycle
// Modports:
//   master    data source side
//   slave     transmitter side
interface odd_parity_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/odd_parity_tx.sv
// rtl/odd_parity_tx.sv - serial transmitter framing a word with odd parity
//
// Frame on tx_out: start (0), DATA_W data bits LSB first, odd parity bit,
// stop (1). Every bit is held for CLKS_PER_BIT clock cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   s          word handshake (data_in / valid_in / ready_out), slave side
//   tx_out     serial line, idles high, registered
//   busy       a frame is in progress
//   parity_out odd parity (~^data) of the most recently accepted word
module odd_parity_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    odd_parity_tx_if.slave   s,
    output logic             tx_out,
    output logic             busy,
    output logic             parity_out
);

    // A one-cycle bit still needs a 1-bit counter that simply stays at 0.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   shift_reg, shift_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                par_n;
    logic                tx_n;
    logic                tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            cnt        <= '0;
            parity_out <= 1'b0;
            tx_out     <= 1'b1;
        end else begin
            state      <= state_n;
            shift_reg  <= shift_n;
            bit_cnt    <= bit_n;
            cnt        <= cnt_n;
            parity_out <= par_n;
            tx_out     <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        bit_n   = bit_cnt;
        cnt_n   = cnt;
        par_n   = parity_out;
        tick    = (cnt == CNT_LAST);

        if (state != IDLE) begin
            cnt_n = tick ? '0 : cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (s.valid_in) begin
                    state_n = START;
                    shift_n = s.data_in;
                    par_n   = ~^s.data_in;
                    bit_n   = '0;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (tick) state_n = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_n = shift_reg >> 1;
                    bit_n   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) state_n = PARITY;
                end
            end
            PARITY: begin
                if (tick) state_n = STOP;
            end
            STOP: begin
                if (tick) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // tx_out is registered from the next-cycle values so the line only ever
    // changes on a clock edge, directly to the new bit.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = par_n;
            default: tx_n = 1'b1;
        endcase
    end

    assign busy        = (state != IDLE);
    assign s.ready_out = (state == IDLE) && !rst;

endmodule

// File: tb/tb_odd_parity_tx.sv
// tb/tb_odd_parity_tx.sv - directed self-checking bench for odd_parity_tx
module tb_odd_parity_tx;

    logic clk = 1'b0;
    logic rst;
    logic tx0, busy0, par0;
    logic tx1, busy1, par1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    odd_parity_tx_if #(.DATA_W(8)) bus0 ();
    odd_parity_tx_if #(.DATA_W(8)) bus1 ();

    odd_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .s          (bus0),
        .tx_out     (tx0),
        .busy       (busy0),
        .parity_out (par0)
    );

    odd_parity_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .s          (bus1),
        .tx_out     (tx1),
        .busy       (busy1),
        .parity_out (par1)
    );

    // Samples one 44-cycle frame of dut0, starting at the cycle after accept.
    task automatic check_frame(input logic [7:0] d, input logic p, input string name,
                               input int toggle_at, input logic [7:0] new_d, input int drop_at);
        logic [10:0] bits;
        int bad;
        int busy_cnt;
        bits = {1'b1, p, d, 1'b0};
        bad = 0;
        busy_cnt = 0;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            if (i == toggle_at) bus0.data_in = new_d;
            if (i == drop_at) bus0.valid_in = 1'b0;
            if (tx0 !== bits[i/4]) bad++;
            if (busy0 === 1'b1) busy_cnt++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s_bits: wrong tx samples=%0d required 0", name, bad);
        end
        checks++;
        if (busy_cnt !== 44) begin
            errors++;
            $display("FAIL %s_busy: busy cycles=%0d required 44", name, busy_cnt);
        end
        checks++;
        if (par0 !== p) begin
            errors++;
            $display("FAIL %s_parity: parity_out=%b required %b", name, par0, p);
        end
    endtask

    // Checks the single idle cycle that follows a frame.
    task automatic check_idle(input string name);
        @(negedge clk);
        checks++;
        if ({tx0, busy0, bus0.ready_out} !== 3'b101) begin
            errors++;
            $display("FAIL %s_idle: tx,busy,ready=%b required 101", name, {tx0, busy0, bus0.ready_out});
        end
    endtask

    task automatic send_one(input logic [7:0] d, input logic p, input string name);
        @(negedge clk);
        checks++;
        if (tx0 !== 1'b1) begin
            errors++;
            $display("FAIL %s_pre: tx_out=%b required 1", name, tx0);
        end
        bus0.data_in  = d;
        bus0.valid_in = 1'b1;
        check_frame(d, p, name, -1, 8'h00, 0);
        check_idle(name);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus0.valid_in = 1'b1;
        bus0.data_in  = 8'hFF;
        bus1.valid_in = 1'b0;
        bus1.data_in  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx0, busy0, par0, bus0.ready_out} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_hold: tx,busy,par,ready=%b required 1000", {tx0, busy0, par0, bus0.ready_out});
        end
        bus0.valid_in = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx0, busy0, par0, bus0.ready_out} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_release: tx,busy,par,ready=%b required 1001", {tx0, busy0, par0, bus0.ready_out});
        end
    endtask

    task automatic test_single_frames;
        send_one(8'h00, 1'b1, "w00");
        send_one(8'h01, 1'b0, "w01");
        send_one(8'hFF, 1'b1, "wFF");
        send_one(8'hA5, 1'b1, "wA5");
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus0.data_in  = 8'h3C;
        bus0.valid_in = 1'b1;
        check_frame(8'h3C, 1'b1, "b2b_first", 10, 8'h07, -1);
        check_idle("b2b_gap");
        check_frame(8'h07, 1'b0, "b2b_second", -1, 8'h00, 0);
        check_idle("b2b_end");
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clk);
        bus0.data_in  = 8'h55;
        bus0.valid_in = 1'b1;
        repeat (14) begin
            @(negedge clk);
            bus0.valid_in = 1'b0;
        end
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: busy=%b required 1", busy0);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx0, busy0, par0} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_abort: tx,busy,par=%b required 100", {tx0, busy0, par0});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx0, busy0, bus0.ready_out} !== 3'b101) begin
            errors++;
            $display("FAIL midrst_ready: tx,busy,ready=%b required 101", {tx0, busy0, bus0.ready_out});
        end
        send_one(8'hA5, 1'b1, "midrst_resend");
    endtask

    // Bench-side odd parity receiver on the CLKS_PER_BIT=1 instance.
    task automatic test_sweep;
        int bad_frames;
        int bad_len;
        logic [10:0] bits;
        int busy_cnt;
        bad_frames = 0;
        bad_len = 0;
        @(negedge clk);
        for (int w = 0; w < 256; w++) begin
            bus1.data_in  = w[7:0];
            bus1.valid_in = 1'b1;
            busy_cnt = 0;
            for (int i = 0; i < 11; i++) begin
                @(negedge clk);
                if (i == 0) bus1.valid_in = 1'b0;
                bits[i] = tx1;
                if (busy1 === 1'b1) busy_cnt++;
            end
            @(negedge clk);
            if (busy1 !== 1'b0 || tx1 !== 1'b1) busy_cnt = -1;
            if (bits[0] !== 1'b0 || bits[10] !== 1'b1 || (^bits[9:1]) !== 1'b1 ||
                bits[8:1] !== w[7:0])
                bad_frames++;
            if (busy_cnt !== 11) bad_len++;
        end
        checks++;
        if (bad_frames !== 0) begin
            errors++;
            $display("FAIL sweep_parity: bad frames=%0d required 0", bad_frames);
        end
        checks++;
        if (bad_len !== 0) begin
            errors++;
            $display("FAIL sweep_length: frames not 11 cycles=%0d required 0", bad_len);
        end
    endtask

    initial begin
        test_reset();
        test_single_frames();
        test_back_to_back();
        test_reset_mid_frame();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
